// File: rtl/prod_accum_u16.sv
// Accumulates a programmed number of unsigned products into a wider sum.
// Optional build macro PROD_ACCUM_SATURATE_EN clamps the sum instead of wrapping.
module prod_accum_u16 #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W:0]     add_sum;
    logic               beat;

    assign beat    = in_valid && (state_q == ACCUM);
    // One extra bit captures the carry out of the accumulator MSB.
    assign add_sum = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        cnt_d   = len;
                        state_d = ACCUM;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            ACCUM: begin
                if (beat) begin
                    cnt_d = cnt_q - 1'b1;
                    if (add_sum[ACC_W]) ovf_d = 1'b1;
`ifdef PROD_ACCUM_SATURATE_EN
                    if (ovf_q || add_sum[ACC_W]) acc_d = '1;
                    else                         acc_d = add_sum[ACC_W-1:0];
`else
                    acc_d = add_sum[ACC_W-1:0];
`endif
                    if (cnt_q == LEN_W'(1)) state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign sum       = acc_q;
    assign overflow  = ovf_q;

endmodule
